// File: rtl/fpu_result_tracker.sv
// fpu_result_tracker
//   Tags every operation issued to the fpu, delays the tag by the fpu's fixed
//   pipeline latency, pairs it with the fpu result/flags at retirement and
//   buffers the complete record in a show-ahead FIFO drained by valid/ready.
//   Also keeps issue, exception and drop statistics.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/op/opA/opB     operation presented to the fpu this cycle
//   fpu_out, fpu_flags      fpu result and flags, sampled when a tag retires
//                           flags = {div_by_zero, zero, underflow, overflow,
//                                    ine, qnan, snan, inf}
//   clr                     synchronous clear of counters and drop_sticky
//   out_valid/out_ready     FIFO head handshake
//   out_op/opA/opB/result/flags  head record (all zero when empty)
//   fifo_count              occupied entries
//   drop_sticky             set once any record has been dropped
//   cnt_issued/exc/dropped  saturating statistics counters
module fpu_result_tracker #(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    input  logic [2:0]                        in_op,
    input  logic [31:0]                       in_opA,
    input  logic [31:0]                       in_opB,
    input  logic [31:0]                       fpu_out,
    input  logic [7:0]                        fpu_flags,
    input  logic                              clr,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [2:0]                        out_op,
    output logic [31:0]                       out_opA,
    output logic [31:0]                       out_opB,
    output logic [31:0]                       out_result,
    output logic [7:0]                        out_flags,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              drop_sticky,
    output logic [CNT_W-1:0]                  cnt_issued,
    output logic [CNT_W-1:0]                  cnt_exc,
    output logic [CNT_W-1:0]                  cnt_dropped
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // Tag pipeline
    logic        p_valid [LATENCY];
    logic [2:0]  p_op    [LATENCY];
    logic [31:0] p_opA   [LATENCY];
    logic [31:0] p_opB   [LATENCY];

    // Capture register: record formed on the retirement edge
    logic        cap_valid;
    logic [2:0]  cap_op;
    logic [31:0] cap_opA;
    logic [31:0] cap_opB;
    logic [31:0] cap_res;
    logic [7:0]  cap_flags;

    // FIFO storage
    logic [2:0]  mem_op    [FIFO_DEPTH];
    logic [31:0] mem_opA   [FIFO_DEPTH];
    logic [31:0] mem_opB   [FIFO_DEPTH];
    logic [31:0] mem_res   [FIFO_DEPTH];
    logic [7:0]  mem_flags [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic retire;
    logic exc;
    logic pop;
    logic push;
    logic drop;

    assign retire = p_valid[LATENCY-1];
    // snan, qnan, overflow, underflow, div_by_zero; ine/inf/zero do not count
    assign exc    = fpu_flags[7] | fpu_flags[5] | fpu_flags[4] | fpu_flags[2] | fpu_flags[1];

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = cap_valid && ((count < CW'(FIFO_DEPTH)) || pop);
    assign drop      = cap_valid && !push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < LATENCY; k++) p_valid[k] <= 1'b0;
            cap_valid <= 1'b0;
        end else begin
            p_valid[0] <= in_valid;
            for (int unsigned k = 1; k < LATENCY; k++) p_valid[k] <= p_valid[k-1];
            cap_valid <= retire;
        end
    end

    // Data paths need no reset: every consumer is qualified by a valid bit.
    always_ff @(posedge clk) begin
        p_op[0]  <= in_op;
        p_opA[0] <= in_opA;
        p_opB[0] <= in_opB;
        for (int unsigned k = 1; k < LATENCY; k++) begin
            p_op[k]  <= p_op[k-1];
            p_opA[k] <= p_opA[k-1];
            p_opB[k] <= p_opB[k-1];
        end
        if (retire) begin
            cap_op    <= p_op[LATENCY-1];
            cap_opA   <= p_opA[LATENCY-1];
            cap_opB   <= p_opB[LATENCY-1];
            cap_res   <= fpu_out;
            cap_flags <= fpu_flags;
        end
        if (push) begin
            mem_op[wr_ptr]    <= cap_op;
            mem_opA[wr_ptr]   <= cap_opA;
            mem_opB[wr_ptr]   <= cap_opB;
            mem_res[wr_ptr]   <= cap_res;
            mem_flags[wr_ptr] <= cap_flags;
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Statistics; clr wins over any increment on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_issued  <= '0;
            cnt_exc     <= '0;
            cnt_dropped <= '0;
            drop_sticky <= 1'b0;
        end else if (clr) begin
            cnt_issued  <= '0;
            cnt_exc     <= '0;
            cnt_dropped <= '0;
            drop_sticky <= 1'b0;
        end else begin
            if (in_valid && (cnt_issued != '1))       cnt_issued  <= cnt_issued + 1'b1;
            if (retire && exc && (cnt_exc != '1))     cnt_exc     <= cnt_exc + 1'b1;
            if (drop && (cnt_dropped != '1))          cnt_dropped <= cnt_dropped + 1'b1;
            if (drop)                                 drop_sticky <= 1'b1;
        end
    end

    assign fifo_count = count;
    assign out_op     = out_valid ? mem_op[rd_ptr]    : '0;
    assign out_opA    = out_valid ? mem_opA[rd_ptr]   : '0;
    assign out_opB    = out_valid ? mem_opB[rd_ptr]   : '0;
    assign out_result = out_valid ? mem_res[rd_ptr]   : '0;
    assign out_flags  = out_valid ? mem_flags[rd_ptr] : '0;

endmodule

// File: tb/tb_fpu_result_tracker.sv
// Testbench for fpu_result_tracker: a simple fpu stand-in returns a bench-chosen
// result LATENCY edges after issue; expected records go into a scoreboard queue
// at issue and are compared when they reach the FIFO head.
module tb_fpu_result_tracker;

    localparam int L  = 4;
    localparam int D  = 8;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [31:0] in_opA;
    logic [31:0] in_opB;
    logic [31:0] fpu_out;
    logic [7:0]  fpu_flags;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [31:0] out_opA;
    logic [31:0] out_opB;
    logic [31:0] out_result;
    logic [7:0]  out_flags;
    logic [3:0]  fifo_count;
    logic        drop_sticky;
    logic [CW-1:0] cnt_issued;
    logic [CW-1:0] cnt_exc;
    logic [CW-1:0] cnt_dropped;

    always #5 clk = ~clk;

    fpu_result_tracker #(.LATENCY(L), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op),
        .in_opA(in_opA), .in_opB(in_opB), .fpu_out(fpu_out), .fpu_flags(fpu_flags),
        .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_opA(out_opA), .out_opB(out_opB), .out_result(out_result),
        .out_flags(out_flags), .fifo_count(fifo_count), .drop_sticky(drop_sticky),
        .cnt_issued(cnt_issued), .cnt_exc(cnt_exc), .cnt_dropped(cnt_dropped)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [7:0]  flg;
    } rec_t;

    rec_t sb[$];
    int total = 0;
    int bad   = 0;

    // fpu stand-in: the result chosen at issue appears LATENCY edges later
    logic [31:0] in_res = '0;
    logic [7:0]  in_flg = '0;
    logic [31:0] d_res [L];
    logic [7:0]  d_flg [L];
    always @(posedge clk) begin
        d_res[0] <= in_res;
        d_flg[0] <= in_flg;
        for (int k = 1; k < L; k++) begin
            d_res[k] <= d_res[k-1];
            d_flg[k] <= d_flg[k-1];
        end
    end
    assign fpu_out   = d_res[L-1];
    assign fpu_flags = d_flg[L-1];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [7:0] flg, input bit track);
        rec_t r;
        in_valid = 1'b1; in_op = op; in_opA = a; in_opB = b; in_res = res; in_flg = flg;
        r = '{op: op, a: a, b: b, res: res, flg: flg};
        if (track) sb.push_back(r);
        @(negedge clk);
        in_valid = 1'b0; in_op = '0; in_opA = '0; in_opB = '0; in_res = '0; in_flg = '0;
    endtask

    task automatic issue_n(input int n, input int seed);
        for (int i = 0; i < n; i++)
            issue(3'(i + seed), 32'h1000_0000 + 32'(seed * 64 + i), 32'hA000_0000 ^ 32'(i * 7),
                  32'hC0DE_0000 + 32'(seed * 64 + i), 8'(i & 8'h49), 1'b1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_drain(input int n);
        rec_t exp_r;
        rec_t act;
        int wait_cnt;
        for (int i = 0; i < n; i++) begin
            wait_cnt = 0;
            while (!out_valid && wait_cnt < 20) begin
                @(negedge clk);
                wait_cnt++;
            end
            total++;
            if (!out_valid) begin
                bad++;
                $display("FAIL drain_wait[%0d]: out_valid=%0b required 1 within 20 cycles", i, out_valid);
                return;
            end
            exp_r = sb.pop_front();
            act = '{op: out_op, a: out_opA, b: out_opB, res: out_result, flg: out_flags};
            total++;
            if (act !== exp_r) begin
                bad++;
                $display("FAIL drain_rec[%0d]: got %h required %h", i, act, exp_r);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        total++;
        if ({out_valid, fifo_count, out_op, out_opA, out_opB, out_result, out_flags} !== '0) begin
            bad++;
            $display("FAIL drain_empty: valid=%0b count=%0d result=%h required all zero",
                     out_valid, fifo_count, out_result);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_opA = '0; in_opB = '0;
        clr = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, fifo_count, drop_sticky, cnt_issued, cnt_exc, cnt_dropped,
             out_op, out_opA, out_opB, out_result, out_flags} !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%0b count=%0d sticky=%0b iss=%0d required all zero",
                     out_valid, fifo_count, drop_sticky, cnt_issued);
        end
        reset_n = 1'b1;
        repeat (L + 2) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL empty_pop: valid=%0b count=%0d required 0/0", out_valid, fifo_count);
        end
    endtask

    task automatic test_single_op();
        issue(3'b000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 8'h00, 1'b1);
        repeat (L) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early: out_valid=%0b required 0 on capture edge", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_result !== 32'h4040_0000 || out_op !== 3'b000 ||
            out_opA !== 32'h3F80_0000 || out_opB !== 32'h4000_0000) begin
            bad++;
            $display("FAIL single_head: valid=%0b res=%h op=%0d a=%h b=%h required 1 40400000 0 3f800000 40000000",
                     out_valid, out_result, out_op, out_opA, out_opB);
        end
        total++;
        if (cnt_issued !== 4'd1 || fifo_count !== 4'd1) begin
            bad++;
            $display("FAIL single_counts: issued=%0d count=%0d required 1/1", cnt_issued, fifo_count);
        end
        test_drain(1);
    endtask

    task automatic test_overflow();
        pulse_clr();
        issue_n(10, 1);
        repeat (L + 2) @(negedge clk);
        total++;
        if (fifo_count !== 4'd8 || cnt_dropped !== 4'd2 || drop_sticky !== 1'b1) begin
            bad++;
            $display("FAIL overflow: count=%0d dropped=%0d sticky=%0b required 8/2/1",
                     fifo_count, cnt_dropped, drop_sticky);
        end
        while (sb.size() > D) void'(sb.pop_back());
        test_drain(8);
    endtask

    task automatic test_full_pop();
        rec_t exp_r;
        rec_t act;
        pulse_clr();
        issue_n(8, 2);
        repeat (L + 2) @(negedge clk);
        total++;
        if (fifo_count !== 4'd8) begin
            bad++;
            $display("FAIL fullpop_fill: count=%0d required 8", fifo_count);
        end
        issue(3'b101, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFACE_0001, 8'h01, 1'b1);
        repeat (L) @(negedge clk);
        exp_r = sb.pop_front();
        act = '{op: out_op, a: out_opA, b: out_opB, res: out_result, flg: out_flags};
        total++;
        if (act !== exp_r) begin
            bad++;
            $display("FAIL fullpop_head: got %h required %h", act, exp_r);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (fifo_count !== 4'd8 || cnt_dropped !== 4'd0 || drop_sticky !== 1'b0) begin
            bad++;
            $display("FAIL fullpop_nodrop: count=%0d dropped=%0d sticky=%0b required 8/0/0",
                     fifo_count, cnt_dropped, drop_sticky);
        end
        test_drain(8);
    endtask

    task automatic test_exceptions();
        pulse_clr();
        issue(3'b011, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 8'h80, 1'b1);
        issue(3'b011, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 8'h08, 1'b1);
        repeat (L + 2) @(negedge clk);
        total++;
        if (cnt_exc !== 4'd1 || fifo_count !== 4'd2) begin
            bad++;
            $display("FAIL exc_count: cnt_exc=%0d count=%0d required 1/2", cnt_exc, fifo_count);
        end
        total++;
        if (out_flags !== 8'h80) begin
            bad++;
            $display("FAIL exc_flags: out_flags=%h required 80", out_flags);
        end
        test_drain(2);
    endtask

    task automatic test_reset_mid();
        pulse_clr();
        issue_n(2, 3);
        repeat (L + 2) @(negedge clk);
        issue_n(3, 4);
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || fifo_count !== 4'd0 || out_result !== 32'd0 || cnt_issued !== 4'd0) begin
            bad++;
            $display("FAIL reset_async: valid=%0b count=%0d res=%h iss=%0d required 0/0/0/0",
                     out_valid, fifo_count, out_result, cnt_issued);
        end
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < L + 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
                bad++;
                $display("FAIL reset_stale[%0d]: valid=%0b count=%0d required 0/0", i, out_valid, fifo_count);
            end
        end
    endtask

    task automatic test_saturation();
        pulse_clr();
        issue_n(20, 5);
        total++;
        if (cnt_issued !== 4'd15) begin
            bad++;
            $display("FAIL sat_issued: cnt_issued=%0d required 15", cnt_issued);
        end
        repeat (L + 2) @(negedge clk);
        total++;
        if (cnt_dropped !== 4'd12 || fifo_count !== 4'd8) begin
            bad++;
            $display("FAIL sat_dropped: dropped=%0d count=%0d required 12/8", cnt_dropped, fifo_count);
        end
        while (sb.size() > D) void'(sb.pop_back());
        clr = 1'b1;
        issue(3'b111, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0BAD_0BAD, 8'h00, 1'b0);
        clr = 1'b0;
        total++;
        if (cnt_issued !== 4'd0 || drop_sticky !== 1'b0) begin
            bad++;
            $display("FAIL clr_override: cnt_issued=%0d sticky=%0b required 0/0", cnt_issued, drop_sticky);
        end
        repeat (L + 2) @(negedge clk);
        total++;
        if (cnt_dropped !== 4'd1 || drop_sticky !== 1'b1 || cnt_issued !== 4'd0) begin
            bad++;
            $display("FAIL clr_after: dropped=%0d sticky=%0b iss=%0d required 1/1/0",
                     cnt_dropped, drop_sticky, cnt_issued);
        end
        test_drain(8);
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_overflow();
        test_full_pop();
        test_exceptions();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
